// File: rtl/log2_pipe.sv
// log2_pipe: pipelined floor/ceil log2 of an unsigned operand.
// The leading one is found by binary search, one result bit per stage,
// behind a valid/ready stream with a single global stall enable.
module log2_pipe #(
   parameter int unsigned WIDTH     = 32,
   parameter bit          CEIL_MODE = 1'b0,
   parameter int unsigned LOGW      = $clog2(WIDTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_num,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [LOGW:0]     out_log,
   output logic              out_zero,
   output logic              out_pow2
);

   // Operand is zero-extended to a power-of-two window before the search.
   localparam int unsigned P = 1 << LOGW;

   logic                en;
   logic                vld_q    [LOGW];
   logic [P-1:0]        win_q    [LOGW];
   logic                sticky_q [LOGW];
   logic [LOGW-1:0]     bits_q   [LOGW];

   logic [P-1:0]        win_d    [LOGW];
   logic                sticky_d [LOGW];
   logic [LOGW-1:0]     bits_d   [LOGW];

   logic                zero_d;
   logic                pow2_d;
   logic                inc_d;

   // Whole pipeline advances together; it only stalls on a held result.
   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   // Stage s halves the window and decides result bit LOGW-1-s.
   for (genvar s = 0; s < LOGW; s++) begin : g_stage
      localparam int unsigned HALF  = P >> (s + 1);
      localparam logic [P-1:0] LMASK = {P{1'b1}} >> (P - HALF);
      logic upper;
      logic lower;

      assign upper       = |(win_q[s] >> HALF);
      assign lower       = |(win_q[s] & LMASK);
      assign win_d[s]    = upper ? (win_q[s] >> HALF) : (win_q[s] & LMASK);
      assign sticky_d[s] = sticky_q[s] | (upper & lower);
      assign bits_d[s]   = bits_q[s] | (LOGW'(upper) << (LOGW - 1 - s));
   end

   // Final-stage flags; the remaining window is a single bit.
   assign zero_d = ~|win_d[LOGW-1];
   assign pow2_d = !zero_d && !sticky_d[LOGW-1];
   assign inc_d  = CEIL_MODE && !pow2_d && !zero_d;

   // Pipeline registers and output register, all gated by the stall enable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < LOGW; s++) begin
            vld_q[s]    <= 1'b0;
            win_q[s]    <= '0;
            sticky_q[s] <= 1'b0;
            bits_q[s]   <= '0;
         end
         out_valid <= 1'b0;
         out_log   <= '0;
         out_zero  <= 1'b0;
         out_pow2  <= 1'b0;
      end else if (en) begin
         vld_q[0]    <= in_valid;
         win_q[0]    <= P'(in_num);
         sticky_q[0] <= 1'b0;
         bits_q[0]   <= '0;
         for (int s = 1; s < LOGW; s++) begin
            vld_q[s]    <= vld_q[s-1];
            win_q[s]    <= win_d[s-1];
            sticky_q[s] <= sticky_d[s-1];
            bits_q[s]   <= bits_d[s-1];
         end
         out_valid <= vld_q[LOGW-1];
         out_log   <= (LOGW+1)'(bits_d[LOGW-1]) + (LOGW+1)'(inc_d);
         out_zero  <= zero_d;
         out_pow2  <= pow2_d;
      end
   end

endmodule

// File: tb/tb_log2_pipe.sv
// tb_log2_pipe: scoreboard bench for log2_pipe (32-bit floor, 32-bit ceil, 12-bit floor).
module tb_log2_pipe;

   typedef struct packed {
      logic [5:0] lg;
      logic       z;
      logic       p;
      logic       c;
      int         acc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        iv   [3];
   logic        ordy [3];
   logic [31:0] n0, n1;
   logic [11:0] n2;

   logic        ir0, ir1, ir2, ov0, ov1, ov2;
   logic        oz0, oz1, oz2, op0, op1, op2;
   logic [5:0]  ol0, ol1;
   logic [4:0]  ol2;

   logic        ir [3];
   logic        ov [3];
   logic        oz [3];
   logic        op [3];
   logic [5:0]  ol [3];

   assign ir[0] = ir0; assign ir[1] = ir1; assign ir[2] = ir2;
   assign ov[0] = ov0; assign ov[1] = ov1; assign ov[2] = ov2;
   assign oz[0] = oz0; assign oz[1] = oz1; assign oz[2] = oz2;
   assign op[0] = op0; assign op[1] = op1; assign op[2] = op2;
   assign ol[0] = ol0; assign ol[1] = ol1; assign ol[2] = {1'b0, ol2};

   log2_pipe #(.WIDTH(32), .CEIL_MODE(1'b0)) u_floor (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0), .in_num(n0),
      .out_valid(ov0), .out_ready(ordy[0]), .out_log(ol0), .out_zero(oz0), .out_pow2(op0));

   log2_pipe #(.WIDTH(32), .CEIL_MODE(1'b1)) u_ceil (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1), .in_num(n1),
      .out_valid(ov1), .out_ready(ordy[1]), .out_log(ol1), .out_zero(oz1), .out_pow2(op1));

   log2_pipe #(.WIDTH(12), .CEIL_MODE(1'b0)) u_w12 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir2), .in_num(n2),
      .out_valid(ov2), .out_ready(ordy[2]), .out_log(ol2), .out_zero(oz2), .out_pow2(op2));

   int   nchk = 0;
   int   nfail = 0;
   int   cyc = 0;
   int   rmode [3];
   int   lat   [3];
   exp_t q0[$], q1[$], q2[$];
   bit          held [3];
   logic [7:0]  hv   [3];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic exp_t mk(input int lg, input bit z, input bit p, input bit c);
      exp_t e;
      e.lg = 6'(lg); e.z = z; e.p = p; e.c = c; e.acc = 0;
      return e;
   endfunction

   // Reference: linear scan for the highest set bit.
   function automatic exp_t model(input int w, input bit ceil, input logic [31:0] v);
      int fl = 0;
      bit pw;
      for (int b = 0; b < w; b++) if (v[b]) fl = b;
      pw = (v != 0) && ((v & (v - 32'd1)) == 0);
      return mk(fl + ((ceil && v != 0 && !pw) ? 1 : 0), v == 0, pw, 1'b0);
   endfunction

   task automatic push(input int i, input exp_t e);
      case (i)
         0: q0.push_back(e);
         1: q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic pop(input int i, output exp_t e, output bit empty);
      empty = 1'b0;
      e = mk(0, 1'b0, 1'b0, 1'b0);
      case (i)
         0: if (q0.size() == 0) empty = 1'b1; else e = q0.pop_front();
         1: if (q1.size() == 0) empty = 1'b1; else e = q1.pop_front();
         default: if (q2.size() == 0) empty = 1'b1; else e = q2.pop_front();
      endcase
   endtask

   task automatic set_in(input int i, input logic val, input logic [31:0] v);
      iv[i] = val;
      case (i)
         0: n0 = v;
         1: n1 = v;
         default: n2 = v[11:0];
      endcase
   endtask

   // Present one operand and hold it until accepted; record expectation.
   task automatic send(input int i, input logic [31:0] v, input exp_t e);
      int t = 0;
      @(negedge clk); #1;
      set_in(i, 1'b1, v);
      while (!ir[i] && t < 200) begin
         @(negedge clk); #1;
         t++;
      end
      if (!ir[i]) begin
         nchk++; nfail++;
         $display("FAIL accept_timeout: inst %0d operand %0h never accepted", i, v);
      end else begin
         e.acc = cyc + 1;
         push(i, e);
      end
   endtask

   task automatic idle(input int i);
      @(negedge clk); #1;
      set_in(i, 1'b0, 32'h0);
   endtask

   task automatic drain();
      int t = 0;
      while ((q0.size() + q1.size() + q2.size()) != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if ((q0.size() + q1.size() + q2.size()) != 0) begin
         nchk++; nfail++;
         $display("FAIL drain_timeout: %0d results outstanding", q0.size() + q1.size() + q2.size());
      end
      repeat (2) @(negedge clk);
   endtask

   // Monitor for one instance: handshake rule, stall stability, scoreboard.
   task automatic mon(input int i);
      exp_t e;
      bit empty;
      logic [7:0] act;
      act = {ol[i], oz[i], op[i]};
      chk("in_ready", 32'(ir[i]), 32'(!(ov[i] && !ordy[i])));
      if (held[i]) begin
         chk("hold_valid", 32'(ov[i]), 32'd1);
         chk("hold_data", 32'(act), 32'(hv[i]));
      end
      held[i] = ov[i] && !ordy[i];
      hv[i]   = act;
      if (ov[i] && ordy[i]) begin
         pop(i, e, empty);
         if (empty) begin
            nchk++; nfail++;
            $display("FAIL unexpected_output: inst %0d got %0h with nothing expected", i, act);
         end else begin
            chk("result", 32'(act), 32'({e.lg, e.z, e.p}));
            if (e.c) chk("latency", 32'(cyc - e.acc), 32'(lat[i]));
         end
      end
   endtask

   always @(negedge clk) begin
      #2;
      if (rst) begin
         for (int i = 0; i < 3; i++) held[i] = 1'b0;
      end else begin
         for (int i = 0; i < 3; i++) mon(i);
      end
   end

   // Consumer ready: 0 = always ready, 1 = random, 2 = stalled.
   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < 3; i++)
            ordy[i] = (rmode[i] == 1) ? 1'($urandom_range(0, 1)) : (rmode[i] != 2);
      end
   end

   initial begin
      logic [31:0] v;
      lat[0] = 5; lat[1] = 5; lat[2] = 4;
      for (int i = 0; i < 3; i++) begin
         rmode[i] = 0; iv[i] = 1'b0; ordy[i] = 1'b1; held[i] = 1'b0; hv[i] = '0;
      end
      n0 = '0; n1 = '0; n2 = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("rst_out_valid", 32'(ov[i]), 32'd0);
         chk("rst_out_log",   32'(ol[i]), 32'd0);
         chk("rst_out_zero",  32'(oz[i]), 32'd0);
         chk("rst_out_pow2",  32'(op[i]), 32'd0);
         chk("rst_in_ready",  32'(ir[i]), 32'd1);
      end

      // 32-bit floor, back-to-back
      send(0, 32'h8000_0000, mk(31, 1'b0, 1'b1, 1'b1));
      send(0, 32'h0000_0001, mk(0,  1'b0, 1'b1, 1'b1));
      send(0, 32'h0000_0000, mk(0,  1'b1, 1'b0, 1'b1));
      send(0, 32'h0000_00FF, mk(7,  1'b0, 1'b0, 1'b1));
      send(0, 32'h0001_0001, mk(16, 1'b0, 1'b0, 1'b1));
      idle(0);

      // 32-bit ceil
      send(1, 32'h8000_0001, mk(32, 1'b0, 1'b0, 1'b1));
      send(1, 32'h0000_0010, mk(4,  1'b0, 1'b1, 1'b1));
      send(1, 32'h0000_0011, mk(5,  1'b0, 1'b0, 1'b1));
      send(1, 32'h0000_0000, mk(0,  1'b1, 1'b0, 1'b1));
      send(1, 32'h0000_0001, mk(0,  1'b0, 1'b1, 1'b1));
      idle(1);

      // 12-bit floor
      send(2, 32'h0000_0FFF, mk(11, 1'b0, 1'b0, 1'b1));
      send(2, 32'h0000_0800, mk(11, 1'b0, 1'b1, 1'b1));
      send(2, 32'h0000_0001, mk(0,  1'b0, 1'b1, 1'b1));
      idle(2);
      drain();

      // Random operands under random backpressure
      rmode[0] = 1;
      for (int k = 0; k < 10; k++) begin
         v = $urandom >> $urandom_range(0, 31);
         send(0, v, model(32, 1'b0, v));
         if ($urandom_range(0, 2) == 0) idle(0);
      end
      idle(0);
      drain();
      rmode[0] = 0;
      drain();

      // Reset with three operands in flight and the output stalled
      rmode[0] = 2;
      send(0, 32'h0000_0100, mk(8, 1'b0, 1'b1, 1'b0));
      send(0, 32'h0000_0300, mk(9, 1'b0, 1'b0, 1'b0));
      send(0, 32'h0000_0007, mk(2, 1'b0, 1'b0, 1'b0));
      idle(0);
      repeat (8) @(negedge clk);
      chk("stalled_valid", 32'(ov[0]), 32'd1);
      #3 rst = 1'b1;
      #1;
      chk("async_rst_valid", 32'(ov[0]), 32'd0);
      q0.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      rmode[0] = 0;
      repeat (10) @(negedge clk);
      send(0, 32'h0000_1234, mk(12, 1'b0, 1'b0, 1'b1));
      idle(0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end

endmodule
